// File: rtl/storage_bridge_pkg.sv
// Shared types and defaults for the multi-port Wishbone-to-SRAM storage bridge.
// Holds the per-port handshake states, the read-latency range check and the default decode constants.
package storage_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RESP
  } port_state_t;

  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 3;

  localparam logic [23:0] RW0_BASE_DEF = 24'h00_0000;
  localparam logic [23:0] RW1_BASE_DEF = 24'h10_0000;
  localparam logic [23:0] RO_BASE_DEF  = 24'h20_0000;
  localparam logic [23:0] ADR_MASK_DEF = 24'hFF_0000;

  function automatic bit read_lat_ok(input int lat);
    return (lat >= READ_LAT_MIN) && (lat <= READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/storage_port_fsm.sv
// One Wishbone slave port: decode, SRAM enable strobes, latency wait and registered response.
// Write/err respond 1 cycle after accept, reads READ_LAT+1; strobe is ignored until the port is back in IDLE.
module storage_port_fsm
  import storage_bridge_pkg::*;
#(
  parameter int              NB       = 1,
  parameter bit              WR_OK    = 1'b1,
  parameter int              READ_LAT = 1,
  parameter logic [NB*24-1:0] BASES   = '0,
  parameter logic [23:0]     ADR_MASK = ADR_MASK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc,
  input  logic              stb,
  input  logic              we,
  input  logic [23:0]       adr,
  input  logic [NB*32-1:0]  rdata,
  output logic              ack,
  output logic              err,
  output logic [31:0]       dat,
  output logic [NB-1:0]     ena,
  output logic [NB-1:0]     wen
);

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  port_state_t   state;
  logic [1:0]    cnt;
  logic [IW-1:0] blk;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          valid;
  logic          go;

  // Scan downwards so the lowest matching block wins on overlapping bases.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = NB - 1; k >= 0; k--) begin
      if ((adr & ADR_MASK) == BASES[24*k +: 24]) begin
        hit     = 1'b1;
        hit_idx = k[IW-1:0];
      end
    end
  end

  assign valid = cyc & stb & (state == ST_IDLE) & ~rst;
  assign go    = valid & hit & (WR_OK | ~we);

  always_comb begin
    ena = '1;
    wen = '1;
    if (go) begin
      ena[hit_idx] = 1'b0;
      if (we) wen[hit_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      blk   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dat   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid) begin
            if (go) begin
              blk <= hit_idx;
              if (we) begin
                ack   <= 1'b1;
                state <= ST_RESP;
              end else begin
                cnt   <= 2'(READ_LAT - 1);
                state <= ST_RD_WAIT;
              end
            end else begin
              err   <= 1'b1;
              state <= ST_RESP;
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 2'd1;
          end else begin
            dat   <= rdata[32*blk +: 32];
            ack   <= 1'b1;
            state <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack   <= 1'b0;
          err   <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/storage_bridge_wb_mp.sv
// Wishbone bridge from the management SoC to NUM_RW read/write SRAM blocks plus one read-only SRAM.
// Two independent ports; write/err answer in 1 cycle, reads in READ_LAT+1, one access in flight per port.
module storage_bridge_wb_mp
  import storage_bridge_pkg::*;
#(
  parameter int                   NUM_RW   = 2,
  parameter int                   RAM_AW   = 8,
  parameter int                   READ_LAT = 1,
  parameter logic [NUM_RW*24-1:0] RW_BASE  = {RW1_BASE_DEF, RW0_BASE_DEF},
  parameter logic [23:0]          RO_BASE  = RO_BASE_DEF,
  parameter logic [23:0]          ADR_MASK = ADR_MASK_DEF
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [3:0]            wb_sel_i,
  input  logic                  wb_we_i,
  input  logic                  wb_cyc_i,
  input  logic [1:0]            wb_stb_i,
  output logic [1:0]            wb_ack_o,
  output logic [1:0]            wb_err_o,
  output logic [31:0]           wb_rw_dat_o,
  output logic [31:0]           wb_ro_dat_o,
  output logic [NUM_RW-1:0]     mgmt_ena,
  output logic [NUM_RW-1:0]     mgmt_wen,
  output logic [NUM_RW*4-1:0]   mgmt_wen_mask,
  output logic [RAM_AW-1:0]     mgmt_addr,
  output logic [31:0]           mgmt_wdata,
  input  logic [NUM_RW*32-1:0]  mgmt_rdata,
  output logic                  mgmt_ena_ro,
  output logic [RAM_AW-1:0]     mgmt_addr_ro,
  input  logic [31:0]           mgmt_rdata_ro
);

  if (!read_lat_ok(READ_LAT)) begin : g_bad_lat
    $error("storage_bridge_wb_mp: READ_LAT must be 1..3");
  end
  if (NUM_RW < 1 || NUM_RW > 8) begin : g_bad_num
    $error("storage_bridge_wb_mp: NUM_RW must be 1..8");
  end

  logic ro_ena;
  logic ro_wen;
  logic unused_adr;

  storage_port_fsm #(
    .NB       (NUM_RW),
    .WR_OK    (1'b1),
    .READ_LAT (READ_LAT),
    .BASES    (RW_BASE),
    .ADR_MASK (ADR_MASK)
  ) u_rw_port (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .cyc   (wb_cyc_i),
    .stb   (wb_stb_i[0]),
    .we    (wb_we_i),
    .adr   (wb_adr_i[23:0]),
    .rdata (mgmt_rdata),
    .ack   (wb_ack_o[0]),
    .err   (wb_err_o[0]),
    .dat   (wb_rw_dat_o),
    .ena   (mgmt_ena),
    .wen   (mgmt_wen)
  );

  storage_port_fsm #(
    .NB       (1),
    .WR_OK    (1'b0),
    .READ_LAT (READ_LAT),
    .BASES    (RO_BASE),
    .ADR_MASK (ADR_MASK)
  ) u_ro_port (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .cyc   (wb_cyc_i),
    .stb   (wb_stb_i[1]),
    .we    (wb_we_i),
    .adr   (wb_adr_i[23:0]),
    .rdata (mgmt_rdata_ro),
    .ack   (wb_ack_o[1]),
    .err   (wb_err_o[1]),
    .dat   (wb_ro_dat_o),
    .ena   (ro_ena),
    .wen   (ro_wen)
  );

  always_comb begin
    mgmt_wen_mask = '0;
    for (int k = 0; k < NUM_RW; k++) begin
      mgmt_wen_mask[4*k +: 4] = mgmt_wen[k] ? 4'h0 : wb_sel_i;
    end
  end

  // The RO macro has no write path, so an enable that came with a write is never let through.
  assign mgmt_ena_ro  = ro_ena | ~ro_wen;
  assign mgmt_addr    = wb_adr_i[RAM_AW+1:2];
  assign mgmt_addr_ro = wb_adr_i[RAM_AW+1:2];
  assign mgmt_wdata   = wb_dat_i;
  assign unused_adr   = ^{wb_adr_i[31:24], wb_adr_i[1:0]};

endmodule

// File: tb/tb_storage_bridge_wb_mp.sv
// Scoreboard bench for storage_bridge_wb_mp: default instance plus a 4-block, READ_LAT=3 instance.
module tb_storage_bridge_wb_mp;

  typedef struct {
    bit          is_err;
    bit          chk_dat;
    logic [31:0] dat;
    int          exp_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0;
  logic        cyc = 1'b0;
  logic [1:0]  stb = '0;
  logic [1:0]  stb4 = '0;

  logic [1:0]  ack, err, ack4, err4;
  logic [31:0] rw_dat, ro_dat, rw_dat4, ro_dat4;
  logic [1:0]  ena, wen;
  logic [7:0]  wmask;
  logic [7:0]  maddr, maddr_ro, maddr4, maddr_ro4;
  logic [31:0] mwdata, mwdata4;
  logic [63:0] rdata;
  logic        ena_ro, ena_ro4;
  logic [31:0] rdata_ro;
  logic [3:0]  ena4, wen4;
  logic [15:0] wmask4;
  logic [127:0] rdata4;

  int cyc_cnt = 0;
  int total = 0;
  int bad = 0;
  exp_t q[3][$];
  exp_t it;
  string chn[3] = '{"rw", "ro", "rw4"};

  logic [31:0] mem [2][256];
  logic [31:0] rd_q [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  storage_bridge_wb_mp u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_ack_o(ack), .wb_err_o(err),
    .wb_rw_dat_o(rw_dat), .wb_ro_dat_o(ro_dat), .mgmt_ena(ena), .mgmt_wen(wen),
    .mgmt_wen_mask(wmask), .mgmt_addr(maddr), .mgmt_wdata(mwdata), .mgmt_rdata(rdata),
    .mgmt_ena_ro(ena_ro), .mgmt_addr_ro(maddr_ro), .mgmt_rdata_ro(rdata_ro)
  );

  storage_bridge_wb_mp #(
    .NUM_RW(4), .READ_LAT(3),
    .RW_BASE({24'h30_0000, 24'h10_0000, 24'h10_0000, 24'h00_0000})
  ) u_dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb4), .wb_ack_o(ack4), .wb_err_o(err4),
    .wb_rw_dat_o(rw_dat4), .wb_ro_dat_o(ro_dat4), .mgmt_ena(ena4), .mgmt_wen(wen4),
    .mgmt_wen_mask(wmask4), .mgmt_addr(maddr4), .mgmt_wdata(mwdata4), .mgmt_rdata(rdata4),
    .mgmt_ena_ro(ena_ro4), .mgmt_addr_ro(maddr_ro4), .mgmt_rdata_ro(32'h0)
  );

  // Two-block SRAM with 1-cycle read latency behind the default instance.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        rd_q[k] <= '0;
        for (int i = 0; i < 256; i++) mem[k][i] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!ena[k]) begin
          if (!wen[k]) begin
            for (int b = 0; b < 4; b++)
              if (wmask[4*k+b]) mem[k][maddr][8*b +: 8] <= mwdata[8*b +: 8];
          end else begin
            rd_q[k] <= mem[k][maddr];
          end
        end
      end
    end
  end
  assign rdata    = {rd_q[1], rd_q[0]};
  assign rdata_ro = {8'hC0, cyc_cnt[23:0]};

  // Time-stamped read data, so the capture edge shows up in the returned word.
  always_comb begin
    rdata4 = '0;
    for (int k = 0; k < 4; k++) rdata4[32*k +: 32] = {8'hB0 + 8'(k), cyc_cnt[23:0]};
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic expect_resp(input int c, input bit e, input bit cd, input logic [31:0] d, input int en);
    exp_t x;
    x.is_err = e; x.chk_dat = cd; x.dat = d; x.exp_edge = en;
    q[c].push_back(x);
  endtask

  task automatic start(input logic [1:0] s, input logic [1:0] s4, input logic [31:0] a,
                       input logic w, input logic [31:0] d, input logic [3:0] sl);
    cyc = 1'b1; stb = s; stb4 = s4; adr = a; we = w; wdat = d; sel = sl;
    #1;
  endtask

  task automatic finish_acc(input int n);
    @(posedge clk); #1;
    stb = '0; stb4 = '0; cyc = 1'b0; we = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2:0]  a_v, e_v;
    logic [31:0] d_v [3];
    a_v = {ack4[0], ack[1], ack[0]};
    e_v = {err4[0], err[1], err[0]};
    d_v[0] = rw_dat; d_v[1] = ro_dat; d_v[2] = rw_dat4;
    for (int c = 0; c < 3; c++) begin
      if (a_v[c] | e_v[c]) begin
        if (q[c].size() == 0) begin
          total++; bad++;
          $display("FAIL %s unexpected response ack=%0b err=%0b at edge %0d", chn[c], a_v[c], e_v[c], cyc_cnt);
        end else begin
          it = q[c].pop_front();
          chk({chn[c], "_resp"}, {30'd0, a_v[c], e_v[c]}, it.is_err ? 32'd1 : 32'd2);
          chk({chn[c], "_edge"}, 32'(cyc_cnt), 32'(it.exp_edge));
          if (it.chk_dat) chk({chn[c], "_dat"}, d_v[c], it.dat);
        end
      end
    end
  end

  initial begin
    int p;
    // Reset with a live read request: enables must stay high.
    cyc = 1'b1; stb = 2'b11; stb4 = 2'b01; adr = 32'h0010_0040;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ena", {30'd0, ena}, 32'h3);
    chk("rst_ena_ro", {31'd0, ena_ro}, 32'h1);
    chk("rst_ena4", {28'd0, ena4}, 32'hF);
    chk("rst_ack_err", {28'd0, ack, err}, 32'h0);
    chk("rst_rw_dat", rw_dat, 32'h0);
    chk("rst_ro_dat", ro_dat, 32'h0);
    stb = '0; stb4 = '0; cyc = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Write 0xDEADBEEF to block 1.
    p = cyc_cnt;
    expect_resp(0, 0, 0, 0, p + 1);
    start(2'b01, 2'b00, 32'h0010_0040, 1'b1, 32'hDEAD_BEEF, 4'hF);
    chk("wr_ena", {30'd0, ena}, 32'h1);
    chk("wr_wen", {30'd0, wen}, 32'h1);
    chk("wr_addr", {24'd0, maddr}, 32'h10);
    chk("wr_mask", {24'd0, wmask}, 32'hF0);
    chk("wr_wdata", mwdata, 32'hDEAD_BEEF);
    finish_acc(2);

    // Read it back: ack READ_LAT+1 = 2 cycles after accept.
    p = cyc_cnt;
    expect_resp(0, 0, 1, 32'hDEAD_BEEF, p + 2);
    start(2'b01, 2'b00, 32'h0010_0040, 1'b0, 32'h0, 4'hF);
    chk("rd_ena", {30'd0, ena}, 32'h1);
    chk("rd_wen", {30'd0, wen}, 32'h3);
    chk("rd_mask", {24'd0, wmask}, 32'h0);
    finish_acc(3);

    // Partial byte write to block 0, then read the merged word.
    p = cyc_cnt;
    expect_resp(0, 0, 0, 0, p + 1);
    start(2'b01, 2'b00, 32'h0000_0008, 1'b1, 32'h1122_3344, 4'b0101);
    chk("bm_ena", {30'd0, ena}, 32'h2);
    chk("bm_mask", {24'd0, wmask}, 32'h05);
    chk("bm_addr", {24'd0, maddr}, 32'h02);
    finish_acc(2);
    p = cyc_cnt;
    expect_resp(0, 0, 1, 32'h0022_0044, p + 2);
    start(2'b01, 2'b00, 32'h0000_0008, 1'b0, 32'h0, 4'hF);
    finish_acc(3);

    // Unmapped address on the RW port.
    p = cyc_cnt;
    expect_resp(0, 1, 0, 0, p + 1);
    start(2'b01, 2'b00, 32'h0030_0000, 1'b0, 32'h0, 4'hF);
    chk("miss_ena", {30'd0, ena}, 32'h3);
    chk("miss_ena_ro", {31'd0, ena_ro}, 32'h1);
    finish_acc(2);

    // Write on the RO port at its own base is refused.
    p = cyc_cnt;
    expect_resp(1, 1, 0, 0, p + 1);
    start(2'b10, 2'b00, 32'h0020_0000, 1'b1, 32'h5555_5555, 4'hF);
    chk("ro_wr_ena_ro", {31'd0, ena_ro}, 32'h1);
    finish_acc(2);

    // Both ports in one cycle: RW write hits, RO misses.
    p = cyc_cnt;
    expect_resp(0, 0, 0, 0, p + 1);
    expect_resp(1, 1, 0, 0, p + 1);
    start(2'b11, 2'b00, 32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 4'hF);
    chk("cc_ena", {30'd0, ena}, 32'h2);
    finish_acc(2);

    // Both ports in one cycle: RO read hits, RW misses.
    p = cyc_cnt;
    expect_resp(0, 1, 0, 0, p + 1);
    expect_resp(1, 0, 1, {8'hC0, 24'(p + 1)}, p + 2);
    start(2'b11, 2'b00, 32'h0020_0004, 1'b0, 32'h0, 4'hF);
    chk("cc_ena_ro", {31'd0, ena_ro}, 32'h0);
    chk("cc_addr_ro", {24'd0, maddr_ro}, 32'h01);
    chk("cc_ena_rw", {30'd0, ena}, 32'h3);
    finish_acc(3);

    p = cyc_cnt;
    expect_resp(0, 0, 1, 32'hA5A5_A5A5, p + 2);
    start(2'b01, 2'b00, 32'h0000_0010, 1'b0, 32'h0, 4'hF);
    finish_acc(3);

    // Strobe held for 5 edges: writes accepted every other edge.
    p = cyc_cnt;
    expect_resp(0, 0, 0, 0, p + 1);
    expect_resp(0, 0, 0, 0, p + 3);
    expect_resp(0, 0, 0, 0, p + 5);
    start(2'b01, 2'b00, 32'h0010_0044, 1'b1, 32'h0BAD_F00D, 4'hF);
    repeat (4) @(posedge clk);
    finish_acc(3);

    // 4-block instance, READ_LAT=3: block 3 read, ack on the 4th cycle.
    p = cyc_cnt;
    expect_resp(2, 0, 1, {8'hB3, 24'(p + 3)}, p + 4);
    start(2'b00, 2'b01, 32'h0030_0020, 1'b0, 32'h0, 4'hF);
    chk("l3_ena4", {28'd0, ena4}, 32'h7);
    chk("l3_addr4", {24'd0, maddr4}, 32'h08);
    finish_acc(6);

    // Overlapping bases for blocks 1 and 2: block 1 wins.
    p = cyc_cnt;
    expect_resp(2, 0, 1, {8'hB1, 24'(p + 3)}, p + 4);
    start(2'b00, 2'b01, 32'h0010_0000, 1'b0, 32'h0, 4'hF);
    chk("ovl_ena4", {28'd0, ena4}, 32'hD);
    finish_acc(6);

    // Reset while in RD_WAIT: no ack, data cleared.
    start(2'b00, 2'b01, 32'h0030_0020, 1'b0, 32'h0, 4'hF);
    @(posedge clk); #1;
    rst = 1'b1; stb4 = '0; cyc = 1'b0;
    @(posedge clk); #1;
    chk("rr_dat4", rw_dat4, 32'h0);
    chk("rr_ack4", {30'd0, ack4}, 32'h0);
    chk("rr_ena4", {28'd0, ena4}, 32'hF);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    p = cyc_cnt;
    expect_resp(2, 0, 1, {8'hB0, 24'(p + 3)}, p + 4);
    start(2'b00, 2'b01, 32'h0000_0004, 1'b0, 32'h0, 4'hF);
    finish_acc(8);

    for (int c = 0; c < 3; c++) chk({chn[c], "_pending"}, 32'(q[c].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
